holy_axi_arbiter: RTL and testbench

//  Parametrised N-channel AXI burst arbiter: NUM_CH cache-side masters share one external AXI master port.

---
 rtl/holy_core_pkg.sv | 15 +
 rtl/holy_axi_arbiter_if.sv | 51 +++++
 rtl/holy_rr_picker.sv | 48 ++++
 rtl/holy_axi_arbiter.sv | 149 ++++++++++++++
 tb/tb_holy_axi_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/holy_core_pkg.sv
// Shared types and constants for the holy AXI burst arbiter.
package holy_core_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_RD_ADDR,
    ARB_RD_DATA,
    ARB_WR_ADDR,
    ARB_WR_DATA,
    ARB_WR_RESP
  } arb_state_t;

endpackage

// File: rtl/holy_axi_arbiter_if.sv
// AXI bundle for the arbiter. NUM_CH=1 gives the external master port;
// NUM_CH=N gives the cache-side bundle with per-channel valid/ready/address/
// write data, while read data, responses and rlast stay single (broadcast).
interface holy_axi_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  import holy_core_pkg::*;

  localparam int STRB_W = DATA_W / 8;

  logic [NUM_CH-1:0]           arvalid;
  logic [NUM_CH-1:0]           arready;
  logic [NUM_CH*ADDR_W-1:0]    araddr;
  logic [NUM_CH*AXI_LEN_W-1:0] arlen;
  logic [NUM_CH-1:0]           rvalid;
  logic [NUM_CH-1:0]           rready;
  logic [DATA_W-1:0]           rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic [NUM_CH-1:0]           awvalid;
  logic [NUM_CH-1:0]           awready;
  logic [NUM_CH*ADDR_W-1:0]    awaddr;
  logic [NUM_CH*AXI_LEN_W-1:0] awlen;
  logic [NUM_CH-1:0]           wvalid;
  logic [NUM_CH-1:0]           wready;
  logic [NUM_CH*DATA_W-1:0]    wdata;
  logic [NUM_CH*STRB_W-1:0]    wstrb;
  logic [NUM_CH-1:0]           wlast;
  logic [NUM_CH-1:0]           bvalid;
  logic [NUM_CH-1:0]           bready;
  logic [1:0]                  bresp;

  modport master (
    output arvalid, araddr, arlen, input arready,
    input  rvalid, rdata, rresp, rlast, output rready,
    output awvalid, awaddr, awlen, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, output arready,
    output rvalid, rdata, rresp, rlast, input rready,
    input  awvalid, awaddr, awlen, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, input bready
  );

endinterface

// File: rtl/holy_rr_picker.sv
// Combinational winner selection for the arbiter: first set request at or
// after rr_ptr (wrapping), plus the pointer value to adopt once the current
// winner's burst completes.
// HOLY_ARB_FIXED_PRIO_EN: strict priority (lowest index wins), pointer pinned to 0.
module holy_rr_picker #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] rr_ptr_i,
  input  logic [$clog2(NUM_CH)-1:0] cur_win_i,
  output logic [$clog2(NUM_CH)-1:0] win_o,
  output logic                      any_req_o,
  output logic [$clog2(NUM_CH)-1:0] nxt_ptr_o
);

  localparam int IDX_W = $clog2(NUM_CH);

  assign any_req_o = |req_i;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    win_o = '0;
    idx   = 0;
`ifdef HOLY_ARB_FIXED_PRIO_EN
    base  = 0;
`else
    base  = 32'(rr_ptr_i);
`endif
    for (int unsigned k = NUM_CH; k > 0; k--) begin
      idx = (base + k - 1) % NUM_CH;
      if (req_i[idx]) win_o = idx[IDX_W-1:0];
    end
  end

  // Pointer moves one past the finishing winner, wrapping to 0.
  always_comb begin
    int unsigned nxt;
`ifdef HOLY_ARB_FIXED_PRIO_EN
    nxt = 0;
`else
    nxt = (32'(cur_win_i) + 1) % NUM_CH;
`endif
    nxt_ptr_o = nxt[IDX_W-1:0];
  end

endmodule

// File: rtl/holy_axi_arbiter.sv
// N-channel AXI burst arbiter: cache-side channels share one external AXI
// master port, one burst in flight, registered grant held until completion.
// HOLY_ARB_FIXED_PRIO_EN selects strict priority instead of round-robin.
module holy_axi_arbiter
  import holy_core_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  holy_axi_arbiter_if.slave         s_axi,
  holy_axi_arbiter_if.master        m_axi,
  output logic [$clog2(NUM_CH)-1:0] grant_id,
  output logic                      busy
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int STRB_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  pick_win, nxt_ptr;
  logic              any_req;
  logic [NUM_CH-1:0] req;

  assign req = s_axi.arvalid | s_axi.awvalid;

  holy_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .cur_win_i (win_q),
    .win_o     (pick_win),
    .any_req_o (any_req),
    .nxt_ptr_o (nxt_ptr)
  );

  // State, grant and fairness pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: decide in IDLE, then follow handshakes; beat count comes from last flags only.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          win_d   = pick_win;
          state_d = s_axi.awvalid[pick_win] ? ARB_WR_ADDR : ARB_RD_ADDR;
        end
      end
      ARB_RD_ADDR: begin
        if (m_axi.arvalid[0] && m_axi.arready[0]) state_d = ARB_RD_DATA;
      end
      ARB_RD_DATA: begin
        if (m_axi.rvalid[0] && m_axi.rready[0] && m_axi.rlast) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = nxt_ptr;
        end
      end
      ARB_WR_ADDR: begin
        if (m_axi.awvalid[0] && m_axi.awready[0]) state_d = ARB_WR_DATA;
      end
      ARB_WR_DATA: begin
        if (m_axi.wvalid[0] && m_axi.wready[0] && m_axi.wlast[0]) state_d = ARB_WR_RESP;
      end
      ARB_WR_RESP: begin
        if (m_axi.bvalid[0] && m_axi.bready[0]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = nxt_ptr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output muxes: only the registered winner is connected, everything else idles at 0.
  always_comb begin
    s_axi.arready = '0;
    s_axi.rvalid  = '0;
    s_axi.awready = '0;
    s_axi.wready  = '0;
    s_axi.bvalid  = '0;
    m_axi.arvalid = '0;
    m_axi.araddr  = '0;
    m_axi.arlen   = '0;
    m_axi.rready  = '0;
    m_axi.awvalid = '0;
    m_axi.awaddr  = '0;
    m_axi.awlen   = '0;
    m_axi.wvalid  = '0;
    m_axi.wdata   = '0;
    m_axi.wstrb   = '0;
    m_axi.wlast   = '0;
    m_axi.bready  = '0;
    case (state_q)
      ARB_RD_ADDR: begin
        m_axi.arvalid        = 1'b1;
        m_axi.araddr         = s_axi.araddr[win_q*ADDR_W +: ADDR_W];
        m_axi.arlen          = s_axi.arlen[win_q*AXI_LEN_W +: AXI_LEN_W];
        s_axi.arready[win_q] = m_axi.arready[0];
      end
      ARB_RD_DATA: begin
        s_axi.rvalid[win_q] = m_axi.rvalid[0];
        m_axi.rready        = s_axi.rready[win_q];
      end
      ARB_WR_ADDR: begin
        m_axi.awvalid        = 1'b1;
        m_axi.awaddr         = s_axi.awaddr[win_q*ADDR_W +: ADDR_W];
        m_axi.awlen          = s_axi.awlen[win_q*AXI_LEN_W +: AXI_LEN_W];
        s_axi.awready[win_q] = m_axi.awready[0];
      end
      ARB_WR_DATA: begin
        m_axi.wvalid        = s_axi.wvalid[win_q];
        m_axi.wdata         = s_axi.wdata[win_q*DATA_W +: DATA_W];
        m_axi.wstrb         = s_axi.wstrb[win_q*STRB_W +: STRB_W];
        m_axi.wlast         = s_axi.wlast[win_q];
        s_axi.wready[win_q] = m_axi.wready[0];
      end
      ARB_WR_RESP: begin
        s_axi.bvalid[win_q] = m_axi.bvalid[0];
        m_axi.bready        = s_axi.bready[win_q];
      end
      default: ;
    endcase
  end

  assign s_axi.rdata = m_axi.rdata;
  assign s_axi.rresp = m_axi.rresp;
  assign s_axi.rlast = m_axi.rlast;
  assign s_axi.bresp = m_axi.bresp;

  assign grant_id = win_q;
  assign busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_holy_axi_arbiter.sv
// Self-checking bench for holy_axi_arbiter: plays both the caches and the
// external memory, predicts each winner from the arbitration rule.
module tb_holy_axi_arbiter;
  import holy_core_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] grant_id;
  logic       busy;

  always #5 clk = ~clk;

  holy_axi_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) s_if ();
  holy_axi_arbiter_if #(.NUM_CH(1), .ADDR_W(AW), .DATA_W(DW)) m_if ();

  holy_axi_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axi    (s_if),
    .m_axi    (m_if),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding requests and the fairness pointer.
  bit [N-1:0]    pend_rd, pend_wr;
  logic [AW-1:0] rd_addr [N];
  logic [AW-1:0] wr_addr [N];
  logic [7:0]    rd_len  [N];
  logic [7:0]    wr_len  [N];
  int            ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input bit [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int next_ptr(input int w);
`ifdef HOLY_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (w + 1) % N;
`endif
  endfunction

  task automatic clear_all();
    s_if.arvalid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.rready = '0;
    s_if.awvalid = '0; s_if.awaddr = '0; s_if.awlen = '0;
    s_if.wvalid = '0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = '0; s_if.bready = '0;
    m_if.arready = '0; m_if.rvalid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = '0;
    m_if.awready = '0; m_if.wready = '0; m_if.bvalid = '0; m_if.bresp = '0;
    pend_rd = '0; pend_wr = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_s_arready"}, s_if.arready, 0);
    check({tag, "_s_rvalid"},  s_if.rvalid,  0);
    check({tag, "_s_awready"}, s_if.awready, 0);
    check({tag, "_s_wready"},  s_if.wready,  0);
    check({tag, "_s_bvalid"},  s_if.bvalid,  0);
    check({tag, "_m_arvalid"}, m_if.arvalid, 0);
    check({tag, "_m_rready"},  m_if.rready,  0);
    check({tag, "_m_awvalid"}, m_if.awvalid, 0);
    check({tag, "_m_wvalid"},  m_if.wvalid,  0);
    check({tag, "_m_bready"},  m_if.bready,  0);
    check({tag, "_m_araddr"},  m_if.araddr,  0);
    check({tag, "_m_awaddr"},  m_if.awaddr,  0);
    check({tag, "_m_arlen"},   m_if.arlen,   0);
    check({tag, "_m_awlen"},   m_if.awlen,   0);
    check({tag, "_busy"},      busy,         0);
    check({tag, "_grant"},     grant_id,     0);
  endtask

  task automatic raise_rd(input int ch, input logic [AW-1:0] a, input logic [7:0] len);
    rd_addr[ch] = a; rd_len[ch] = len; pend_rd[ch] = 1'b1;
    s_if.arvalid[ch] = 1'b1;
    s_if.araddr[ch*AW +: AW] = a;
    s_if.arlen[ch*8 +: 8] = len;
  endtask

  task automatic raise_wr(input int ch, input logic [AW-1:0] a, input logic [7:0] len);
    wr_addr[ch] = a; wr_len[ch] = len; pend_wr[ch] = 1'b1;
    s_if.awvalid[ch] = 1'b1;
    s_if.awaddr[ch*AW +: AW] = a;
    s_if.awlen[ch*8 +: 8] = len;
  endtask

  // Serve one burst for the predicted winner. Call while the DUT is idle,
  // after a posedge and before the following negedge. abort_at >= 0 asserts
  // reset in that read beat instead of completing it.
  task automatic serve(input int addr_dly, input int stall, input logic [1:0] bresp, input int abort_at);
    int ch, b, stalled;
    bit wr, hs, rdy;
    logic [AW-1:0] a;
    logic [7:0] len;
    logic [DW-1:0] d;
    logic [SW-1:0] st;
    logic [1:0] rr;
    ch = rr_pick(pend_rd | pend_wr, ptr);
    wr = pend_wr[ch];
    a   = wr ? wr_addr[ch] : rd_addr[ch];
    len = wr ? wr_len[ch]  : rd_len[ch];
    // decision cycle
    @(negedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_m_arvalid", m_if.arvalid, 0);
    check("idle_m_awvalid", m_if.awvalid, 0);
    @(posedge clk);
    // address phase
    for (int c = 0; c <= addr_dly; c++) begin
      @(negedge clk);
      hs = (c == addr_dly);
      if (wr) m_if.awready = hs; else m_if.arready = hs;
      #1;
      check("grant_id", grant_id, ch);
      check("busy", busy, 1);
      if (wr) begin
        check("m_awvalid", m_if.awvalid, 1);
        check("m_awaddr", m_if.awaddr, a);
        check("m_awlen", m_if.awlen, len);
        check("s_awready", s_if.awready, hs ? (1 << ch) : 0);
        check("m_arvalid_in_wr", m_if.arvalid, 0);
      end else begin
        check("m_arvalid", m_if.arvalid, 1);
        check("m_araddr", m_if.araddr, a);
        check("m_arlen", m_if.arlen, len);
        check("s_arready", s_if.arready, hs ? (1 << ch) : 0);
        check("m_awvalid_in_rd", m_if.awvalid, 0);
      end
      @(posedge clk);
    end
    #1;
    if (wr) begin
      s_if.awvalid[ch] = 1'b0; pend_wr[ch] = 1'b0; m_if.awready = 1'b0;
    end else begin
      s_if.arvalid[ch] = 1'b0; pend_rd[ch] = 1'b0; m_if.arready = 1'b0;
    end
    b = 0; stalled = 0;
    if (!wr) begin
      while (b <= int'(len)) begin
        @(negedge clk);
        d = $urandom; rr = 2'($urandom_range(0, 3));
        m_if.rvalid = 1'b1; m_if.rdata = d; m_if.rresp = rr; m_if.rlast = (b == int'(len));
        rdy = !(b == 1 && stalled < stall);
        s_if.rready = '1; s_if.rready[ch] = rdy;
        #1;
        if (b == abort_at) begin
          rst_n = 1'b0; #1;
          check_quiet("abort");
          clear_all();
          ptr = 0;
          return;
        end
        check("s_rvalid", s_if.rvalid, 1 << ch);
        check("m_rready", m_if.rready, rdy);
        check("s_rdata", s_if.rdata, d);
        check("s_rresp", s_if.rresp, rr);
        check("s_rlast", s_if.rlast, (b == int'(len)));
        @(posedge clk);
        if (rdy) b++; else stalled++;
      end
      #1;
      m_if.rvalid = '0; m_if.rlast = 1'b0; s_if.rready = '0;
    end else begin
      while (b <= int'(len)) begin
        @(negedge clk);
        d = $urandom; st = SW'($urandom);
        s_if.wvalid = '1;
        s_if.wdata = {$urandom, $urandom};
        s_if.wstrb = '1;
        s_if.wlast = '1;
        s_if.wdata[ch*DW +: DW] = d;
        s_if.wstrb[ch*SW +: SW] = st;
        s_if.wlast[ch] = (b == int'(len));
        rdy = !(b == 1 && stalled < stall);
        m_if.wready = rdy;
        #1;
        check("m_wvalid", m_if.wvalid, 1);
        check("m_wdata", m_if.wdata, d);
        check("m_wstrb", m_if.wstrb, st);
        check("m_wlast", m_if.wlast, (b == int'(len)));
        check("s_wready", s_if.wready, rdy ? (1 << ch) : 0);
        @(posedge clk);
        if (rdy) b++; else stalled++;
      end
      #1;
      s_if.wvalid = '0; s_if.wlast = '0; m_if.wready = '0;
      @(negedge clk);
      m_if.bvalid = 1'b1; m_if.bresp = bresp; s_if.bready = '1;
      #1;
      check("s_bvalid", s_if.bvalid, 1 << ch);
      check("s_bresp", s_if.bresp, bresp);
      check("m_bready", m_if.bready, 1);
      @(posedge clk); #1;
      m_if.bvalid = '0; s_if.bready = '0;
    end
    check("busy_drop", busy, 0);
    ptr = next_ptr(ch);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_all();
    ptr = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;

    // Single read on ch1, 4 beats.
    raise_rd(1, 32'h100, 8'd3);
    serve(0, 0, 2'b00, -1);

    // Simultaneous reads; ch0 re-requests while ch1 is still waiting.
    raise_rd(0, 32'h200, 8'd1);
    raise_rd(1, 32'h300, 8'd0);
    serve(0, 0, 2'b00, -1);
    raise_rd(0, 32'h240, 8'd2);
    serve(1, 0, 2'b00, -1);
    serve(0, 0, 2'b00, -1);

    // Write on ch1, awready delayed, error response.
    raise_wr(1, 32'h400, 8'd1);
    serve(2, 0, 2'b10, -1);

    // Write takes precedence over read on the same channel.
    raise_rd(0, 32'h440, 8'd0);
    raise_wr(0, 32'h480, 8'd2);
    serve(0, 1, 2'b00, -1);
    serve(0, 0, 2'b00, -1);

    // Read with cache-side back-pressure.
    raise_rd(0, 32'h500, 8'd3);
    serve(0, 3, 2'b00, -1);

    // Reset in beat 2 of a 4-beat read, then a fresh request.
    raise_rd(0, 32'h600, 8'd3);
    serve(1, 0, 2'b00, 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    raise_rd(1, 32'h700, 8'd3);
    serve(0, 0, 2'b00, -1);

    // Repeated contention between ch0 and ch1.
    for (int r = 0; r < 3; r++) begin
      raise_rd(0, 32'h800 + 32'(r), 8'd1);
      raise_wr(1, 32'h900 + 32'(r), 8'd1);
      serve(0, 0, 2'b01, -1);
      serve(0, 0, 2'b00, -1);
    end

    // Randomised request mixes.
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 1) == 1) raise_rd(c, $urandom, 8'($urandom_range(0, 3)));
        if ($urandom_range(0, 1) == 1) raise_wr(c, $urandom, 8'($urandom_range(0, 3)));
      end
      if ((pend_rd | pend_wr) == '0) raise_rd(r % N, $urandom, 8'd1);
      while ((pend_rd | pend_wr) != '0)
        serve($urandom_range(0, 2), $urandom_range(0, 2), 2'($urandom_range(0, 3)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
